disparo_ctrl: RTL

DISPARO_CTRL -- requirements
Module: disparo_ctrl

---
 rtl/disparo_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/disparo_ctrl.sv
// -----------------------------------------------------------------------------
// disparo_ctrl
// Shot controller for one player of a 5x5 battleship board. The player moves
// an aiming cursor with button pulses, fires at unexplored cells and the
// block records hit/miss results in a shot matrix read by the VGA stage.
//
// Ports
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   turn_en             high while this player holds the turn
//   btn_up/down/left/right  single-cycle move pulses
//   btn_fire            single-cycle fire pulse
//   matriz_barcos_rival [row][col] 2-bit rival ship map, nonzero = ship
//   matriz_disparos     [row][col] shot map: 00 unexplored, 01 miss, 10 hit
//   cursor_x/cursor_y   aim column / row, 0..4
//   shot_done           one-cycle pulse per completed shot
//   hit                 shot result, valid with shot_done
//   repeat_err          one-cycle pulse when firing on an already-shot cell
//   hit_count           number of hits so far
//   all_sunk            game over, every rival ship cell hit
//   fsm_state           current FSM state (IDLE=0 AIM=1 EVAL=2 DONE=3 OVER=4)
//
// Handshake: there is no backpressure. A fire pulse is accepted in AIM in the
// cycle it is high; shot_done is the single-cycle "result valid" strobe and
// hit is meaningful only while shot_done is high.
// -----------------------------------------------------------------------------
module disparo_ctrl #(
    parameter int SHIP_CELLS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  turn_en,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_fire,
    input  logic [4:0][4:0][1:0]  matriz_barcos_rival,
    output logic [4:0][4:0][1:0]  matriz_disparos,
    output logic [2:0]            cursor_x,
    output logic [2:0]            cursor_y,
    output logic                  shot_done,
    output logic                  hit,
    output logic                  repeat_err,
    output logic [3:0]            hit_count,
    output logic                  all_sunk,
    output logic [2:0]            fsm_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AIM  = 3'd1,
        EVAL = 3'd2,
        DONE = 3'd3,
        OVER = 3'd4
    } state_t;

    localparam logic [3:0] SHIP_MAX = 4'(SHIP_CELLS);

    state_t     state;
    state_t     next_state;

    logic [2:0] x_next;
    logic [2:0] y_next;
    logic       take_shot;
    logic       rep_now;
    logic [1:0] cell_aim;
    logic       ship_here;

    // Target cell latched at fire time so cursor activity cannot disturb it.
    logic [2:0] row_q;
    logic [2:0] col_q;
    logic       result_q;

    assign cell_aim  = matriz_disparos[cursor_y][cursor_x];
    assign ship_here = |matriz_barcos_rival[row_q][col_q];
    assign fsm_state = state;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next state, cursor update and Moore outputs
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        x_next     = cursor_x;
        y_next     = cursor_y;
        take_shot  = 1'b0;
        rep_now    = 1'b0;
        shot_done  = 1'b0;
        hit        = 1'b0;
        all_sunk   = 1'b0;

        case (state)
            IDLE: begin
                if (turn_en) begin
                    next_state = AIM;
                end
            end

            AIM: begin
                // Fire has priority over moves and over losing the turn.
                if (btn_fire) begin
                    if (cell_aim == 2'b00) begin
                        take_shot  = 1'b1;
                        next_state = EVAL;
                    end else begin
                        rep_now = 1'b1;
                    end
                end else if (!turn_en) begin
                    next_state = IDLE;
                end else begin
                    // Opposing pulses on one axis cancel; edges saturate.
                    if (btn_right && !btn_left && cursor_x != 3'd4) begin
                        x_next = cursor_x + 3'd1;
                    end else if (btn_left && !btn_right && cursor_x != 3'd0) begin
                        x_next = cursor_x - 3'd1;
                    end
                    if (btn_down && !btn_up && cursor_y != 3'd4) begin
                        y_next = cursor_y + 3'd1;
                    end else if (btn_up && !btn_down && cursor_y != 3'd0) begin
                        y_next = cursor_y - 3'd1;
                    end
                end
            end

            EVAL: begin
                next_state = DONE;
            end

            DONE: begin
                shot_done = 1'b1;
                hit       = result_q;
                // hit_count was already updated on the EVAL edge.
                next_state = (hit_count == SHIP_MAX) ? OVER : IDLE;
            end

            OVER: begin
                all_sunk = 1'b1;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: cursor, latched target, shot matrix, hit counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cursor_x        <= 3'd0;
            cursor_y        <= 3'd0;
            row_q           <= 3'd0;
            col_q           <= 3'd0;
            result_q        <= 1'b0;
            repeat_err      <= 1'b0;
            hit_count       <= 4'd0;
            matriz_disparos <= '0;
        end else begin
            cursor_x   <= x_next;
            cursor_y   <= y_next;
            repeat_err <= rep_now;

            if (take_shot) begin
                row_q <= cursor_y;
                col_q <= cursor_x;
            end

            if (state == EVAL) begin
                matriz_disparos[row_q][col_q] <= ship_here ? 2'b10 : 2'b01;
                result_q <= ship_here;
                if (ship_here && hit_count != SHIP_MAX) begin
                    hit_count <= hit_count + 4'd1;
                end
            end
        end
    end

endmodule
